// File: rtl/ex_muldiv_pkg.sv
// Shared types for the RV32M multi-cycle execute unit: funct3 op codes,
// FSM state encoding and small op-class decode helpers.
package ex_muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE  = 2'd0,
    MD_CALC  = 2'd1,
    MD_FIXUP = 2'd2,
    MD_DONE  = 2'd3
  } md_state_e;

  function automatic logic op_is_div(input md_op_e op);
    return op[2];
  endfunction

  function automatic logic op_is_rem(input md_op_e op);
    return op[2] & op[1];
  endfunction

  // MUL only keeps the low half, so it can run on raw unsigned operands.
  function automatic logic op_rs1_signed(input md_op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic op_rs2_signed(input md_op_e op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// Issue/writeback handshake bundle between the EX stage and the mul/div unit.
interface ex_muldiv_if #(
  parameter int XLEN  = 32,
  parameter int RD_AW = 5
) ();

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [XLEN-1:0]  in_rs1;
  logic [XLEN-1:0]  in_rs2;
  logic [RD_AW-1:0] in_rd_addr;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_rd_data;
  logic [RD_AW-1:0] out_rd_addr;
  logic             busy;

  modport master (
    output flush, in_valid, in_op, in_rs1, in_rs2, in_rd_addr, out_ready,
    input  in_ready, out_valid, out_rd_data, out_rd_addr, busy
  );

  modport slave (
    input  flush, in_valid, in_op, in_rs1, in_rs2, in_rd_addr, out_ready,
    output in_ready, out_valid, out_rd_data, out_rd_addr, busy
  );

endinterface

// File: rtl/ex_muldiv.sv
// Iterative RV32M unit: radix-2 shift-add multiply and restoring divide on
// operand magnitudes, one result bit per cycle, sign fix-up at the end.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int RD_AW = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  ex_muldiv_if.slave bus
);

  localparam int CNT_W = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + XLEN'(1)) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cond_neg_2x(input logic [2*XLEN-1:0] v, input logic neg);
    return neg ? (~v + (2*XLEN)'(1)) : v;
  endfunction

  md_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             out_valid_q;
  logic [XLEN-1:0]  out_data_q;
  logic [RD_AW-1:0] out_addr_q;

  md_op_e           op_q;
  logic             neg_q;
  logic [XLEN-1:0]  opnd_q;
  logic [2*XLEN-1:0] acc_q;
  logic [2*XLEN-1:0] acc_d;

  md_op_e          op_in;
  logic            accept;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf, mul_zero, special;
  logic [XLEN-1:0] special_res;

  assign op_in  = md_op_e'(bus.in_op);
  assign accept = (state_q == MD_IDLE) && bus.in_valid && !bus.flush;

  assign a_neg = op_rs1_signed(op_in) & bus.in_rs1[XLEN-1];
  assign b_neg = op_rs2_signed(op_in) & bus.in_rs2[XLEN-1];
  assign a_mag = cond_neg(bus.in_rs1, a_neg);
  assign b_mag = cond_neg(bus.in_rs2, b_neg);

  assign div_zero = op_is_div(op_in) && (bus.in_rs2 == '0);
  assign div_ovf  = op_is_div(op_in) && op_rs2_signed(op_in) &&
                    (bus.in_rs1 == MIN_INT) && (bus.in_rs2 == '1);
  assign mul_zero = !op_is_div(op_in) && ((bus.in_rs1 == '0) || (bus.in_rs2 == '0));
  assign special  = div_zero || div_ovf || mul_zero;

  always_comb begin
    special_res = '0;
    if (div_zero)     special_res = op_is_rem(op_in) ? bus.in_rs1 : '1;
    else if (div_ovf) special_res = op_is_rem(op_in) ? '0 : MIN_INT;
  end

  // Shared adder: mul adds the multiplicand into the high half, div trial-subtracts
  // the divisor from the shifted partial remainder (carry out = no borrow).
  logic            div_mode;
  logic [XLEN:0]   add_a, add_b;
  logic [XLEN+1:0] add_sum;

  assign div_mode = op_is_div(op_q);
  assign add_a    = div_mode ? {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]}
                             : {1'b0, acc_q[2*XLEN-1:XLEN]};
  assign add_b    = {1'b0, (div_mode || acc_q[0]) ? opnd_q : {XLEN{1'b0}}};
  assign add_sum  = {1'b0, add_a} + {1'b0, (div_mode ? ~add_b : add_b)}
                  + {{(XLEN+1){1'b0}}, div_mode};

  always_comb begin
    if (!div_mode)                acc_d = {add_sum[XLEN:0], acc_q[XLEN-1:1]};
    else if (add_sum[XLEN+1])     acc_d = {add_sum[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    else                          acc_d = {acc_q[2*XLEN-2:0], 1'b0};
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   fix_res;

  always_comb begin
    prod = cond_neg_2x(acc_q, neg_q);
    case (op_q)
      OP_MUL:                       fix_res = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              fix_res = cond_neg(acc_q[XLEN-1:0], neg_q);
      default:                      fix_res = cond_neg(acc_q[2*XLEN-1:XLEN], neg_q);
    endcase
  end

  // Datapath: no reset, loaded on accept and iterated in CALC.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q   <= op_in;
      neg_q  <= op_is_rem(op_in) ? a_neg : (a_neg ^ b_neg);
      opnd_q <= op_is_div(op_in) ? b_mag : a_mag;
      acc_q  <= {{XLEN{1'b0}}, (op_is_div(op_in) ? a_mag : b_mag)};
    end else if (state_q == MD_CALC) begin
      acc_q  <= acc_d;
    end
  end

  // Control FSM with registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= MD_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
    end else if (bus.flush) begin
      state_q     <= MD_IDLE;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (bus.in_valid) begin
            out_addr_q <= bus.in_rd_addr;
            if (special) begin
              out_data_q  <= special_res;
              out_valid_q <= 1'b1;
              state_q     <= MD_DONE;
            end else begin
              cnt_q   <= CNT_W'(XLEN - 1);
              state_q <= MD_CALC;
            end
          end
        end
        MD_CALC: begin
          if (cnt_q == '0) state_q <= MD_FIXUP;
          else             cnt_q   <= cnt_q - CNT_W'(1);
        end
        MD_FIXUP: begin
          out_data_q  <= fix_res;
          out_valid_q <= 1'b1;
          state_q     <= MD_DONE;
        end
        MD_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= MD_IDLE;
          end
        end
        default: state_q <= MD_IDLE;
      endcase
    end
  end

  assign bus.in_ready    = (state_q == MD_IDLE);
  assign bus.busy        = (state_q != MD_IDLE);
  assign bus.out_valid   = out_valid_q;
  assign bus.out_rd_data = out_data_q;
  assign bus.out_rd_addr = out_addr_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: directed RV32M corner cases plus random ops checked
// against a plain-arithmetic reference model, latency and handshake checks.
module tb_ex_muldiv;

  localparam logic [31:0] MIN_INT = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_mis = 0;

  always #5 clk = ~clk;

  ex_muldiv_if #(.XLEN(32), .RD_AW(5)) bus ();

  ex_muldiv #(.XLEN(32), .RD_AW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sp;
    logic [63:0]        up;
    int                 sa, sb;
    sa = a;
    sb = b;
    case (op)
      3'd0: begin up = {32'd0, a} * {32'd0, b}; return up[31:0]; end
      3'd1: begin sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return sp[63:32]; end
      3'd2: begin sp = $signed({{32{a[31]}}, a}) * $signed({32'd0, b}); return sp[63:32]; end
      3'd3: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == MIN_INT && b == 32'hFFFF_FFFF) return MIN_INT;
        return sa / sb;
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == MIN_INT && b == 32'hFFFF_FFFF) return 32'd0;
        return sa % sb;
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && b == 32'd0) return 1'b1;
    if ((op == 3'd4 || op == 3'd6) && a == MIN_INT && b == 32'hFFFF_FFFF) return 1'b1;
    if (!op[2] && (a == 32'd0 || b == 32'd0)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    bus.in_valid   = 1'b1;
    bus.in_op      = op;
    bus.in_rs1     = a;
    bus.in_rs2     = b;
    bus.in_rd_addr = rd;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input int hold);
    logic [31:0] exp;
    int          exp_lat;
    int          k;
    bit          seen;
    exp     = ref_res(op, a, b);
    exp_lat = is_special(op, a, b) ? 1 : 34;
    wait_ready();
    issue(op, a, b, rd);
    k = 0;
    seen = 1'b0;
    while (k <= 200) begin
      @(negedge clk);
      if (bus.out_valid) begin
        seen = 1'b1;
        break;
      end
      k++;
    end
    chk("out_valid_seen", 32'(seen), 32'd1);
    if (!seen) return;
    chk($sformatf("latency op%0d", op), 32'(k + 1), 32'(exp_lat));
    chk($sformatf("data op%0d a=%h b=%h", op, a, b), bus.out_rd_data, exp);
    chk("rd_addr", {27'd0, bus.out_rd_addr}, {27'd0, rd});
    chk("in_ready_in_done", 32'(bus.in_ready), 32'd0);
    chk("busy_in_done", 32'(bus.busy), 32'd1);
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.in_op    = ~op;
      bus.in_rs1   = $urandom;
      @(negedge clk);
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_data", bus.out_rd_data, exp);
      chk("hold_addr", {27'd0, bus.out_rd_addr}, {27'd0, rd});
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    chk("post_hs_valid", 32'(bus.out_valid), 32'd0);
    chk("post_hs_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return MIN_INT;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(1, 20));
      4:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int cnt_v;
    bus.flush      = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_op      = 3'd0;
    bus.in_rs1     = 32'd0;
    bus.in_rs2     = 32'd0;
    bus.in_rd_addr = 5'd0;
    bus.out_ready  = 1'b0;

    #2;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", bus.out_rd_data, 32'd0);
    chk("rst_out_addr", {27'd0, bus.out_rd_addr}, 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    #20 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Directed corner cases
    do_op(3'd0, 32'd7,        32'hFFFF_FFFD, 5'd1,  0);
    do_op(3'd1, MIN_INT,      MIN_INT,       5'd2,  0);
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 0);
    do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 0);
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2,        5'd5,  0);
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2,        5'd6,  0);
    do_op(3'd5, MIN_INT,      32'd3,         5'd7,  0);
    do_op(3'd4, 32'd5,        32'd0,         5'd8,  0);
    do_op(3'd7, 32'd5,        32'd0,         5'd9,  0);
    do_op(3'd4, MIN_INT,      32'hFFFF_FFFF, 5'd10, 0);
    do_op(3'd6, MIN_INT,      32'hFFFF_FFFF, 5'd11, 0);
    do_op(3'd0, 32'd0,        32'h1234_5678, 5'd0,  0);

    // Backpressure: hold DONE for 10 cycles, then one handshake only
    do_op(3'd6, 32'hDEAD_BEEF, 32'd1234, 5'd17, 10);
    cnt_v = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.out_valid) cnt_v++;
    end
    chk("single_handshake", 32'(cnt_v), 32'd0);

    // Flush mid-divide, with a competing in_valid in the flush cycle
    wait_ready();
    issue(3'd4, 32'd1000, 32'd7, 5'd20);
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_op    = 3'd5;
    bus.in_rs1   = 32'd99;
    bus.in_rs2   = 32'd3;
    @(posedge clk);
    #1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_idle", 32'(bus.in_ready), 32'd1);
    chk("flush_busy", 32'(bus.busy), 32'd0);
    chk("flush_valid", 32'(bus.out_valid), 32'd0);
    cnt_v = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.out_valid) cnt_v++;
    end
    chk("flush_no_result", 32'(cnt_v), 32'd0);
    do_op(3'd5, 32'd99, 32'd3, 5'd21, 0);

    // Async reset mid-operation
    wait_ready();
    issue(3'd1, 32'h1234_5678, 32'h8765_4321, 5'd22);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_data", bus.out_rd_data, 32'd0);
    chk("arst_addr", {27'd0, bus.out_rd_addr}, 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
    do_op(3'd1, 32'h1234_5678, 32'h8765_4321, 5'd22, 0);

    // Random ops against the reference model
    for (int i = 0; i < 40; i++) begin
      do_op(3'($urandom_range(0, 7)), pick(), pick(), 5'($urandom_range(0, 31)),
            int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
